// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, types and helpers for the sprite pipeline
//
// Contents:
//   SPR_SIZE, LINE_W, PIX_W, TRANSP_IDX  sprite geometry and pixel format
//   drawer_state_t                       sprite_drawer FSM states
//   ent_t                                sprite frontend entry (one visible sprite)
//   rom_addr_pack()                      {frame, row, pixel column} pattern ROM address
package sprite_pkg;

    localparam int SPR_SIZE   = 16;
    localparam int LINE_W     = 640;
    localparam int PIX_W      = 8;
    localparam int TRANSP_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } drawer_state_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] col_base;
        logic       flip;
        logic [7:0] frame_id;
        logic [3:0] row_off;
    } ent_t;

    function automatic logic [15:0] rom_addr_pack(
        input logic [7:0] frame,
        input logic [3:0] row,
        input logic [3:0] col
    );
        return {frame, row, col};
    endfunction

endpackage

// File: rtl/sprite_drawer.sv
// rtl/sprite_drawer.sv - renders one 16-pixel sprite row into the next-line buffer
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   abort              cancel the current sprite, back to idle next cycle
//   draw_req           one-cycle request pulse, accepted only while idle
//   col_base, flip,    sprite placement, mirror, pattern frame and row,
//   frame_id, row_off  latched when the request is accepted
//   draw_done          1 = idle/ready, 0 = busy
//   rom_addr, rom_en   pattern ROM read port, one pixel per cycle
//   rom_data           ROM read data, valid one cycle after rom_en
//   lb_we, lb_waddr,   registered line-buffer write port
//   lb_wdata
module sprite_drawer
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             draw_req,
    input  logic [9:0]       col_base,
    input  logic             flip,
    input  logic [7:0]       frame_id,
    input  logic [3:0]       row_off,
    output logic             draw_done,
    output logic [15:0]      rom_addr,
    output logic             rom_en,
    input  logic [PIX_W-1:0] rom_data,
    output logic             lb_we,
    output logic [9:0]       lb_waddr,
    output logic [PIX_W-1:0] lb_wdata
);

    drawer_state_t state, next_state;

    logic [9:0]  col_r;
    logic        flip_r;
    logic [7:0]  frame_r;
    logic [3:0]  row_r;
    logic [3:0]  pix_i;
    logic [3:0]  pix_d;
    logic        valid_d;
    logic        drain_cnt;
    logic [10:0] scr_col;
    logic        pix_write;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rom_en     = 1'b0;
        draw_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                draw_done = 1'b1;
                if (draw_req) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_en = 1'b1;
                if (pix_i == 4'(SPR_SIZE - 1)) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Two cycles: one for the ROM data stage, one for the write register.
                if (drain_cnt) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Flip mirrors the pattern column only; the screen column always advances with i.
    assign rom_addr = rom_addr_pack(frame_r, row_r, flip_r ? (4'd15 - pix_i) : pix_i);

    // 11-bit sum so columns past the line end are clipped instead of wrapping.
    assign scr_col   = {1'b0, col_r} + {7'd0, pix_d};
    assign pix_write = valid_d && (rom_data != PIX_W'(TRANSP_IDX)) && (scr_col < 11'(LINE_W));

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r     <= '0;
            flip_r    <= 1'b0;
            frame_r   <= '0;
            row_r     <= '0;
            pix_i     <= '0;
            pix_d     <= '0;
            valid_d   <= 1'b0;
            drain_cnt <= 1'b0;
            lb_we     <= 1'b0;
            lb_waddr  <= '0;
            lb_wdata  <= '0;
        end else if (abort) begin
            // Discard in-flight pixels; address/data outputs just hold.
            pix_i     <= '0;
            valid_d   <= 1'b0;
            drain_cnt <= 1'b0;
            lb_we     <= 1'b0;
        end else begin
            if (state == ST_IDLE && draw_req) begin
                col_r   <= col_base;
                flip_r  <= flip;
                frame_r <= frame_id;
                row_r   <= row_off;
                pix_i   <= '0;
            end else if (state == ST_FETCH) begin
                pix_i <= pix_i + 4'd1;
            end
            valid_d   <= rom_en;
            pix_d     <= pix_i;
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
            lb_we     <= pix_write;
            if (pix_write) begin
                lb_waddr <= scr_col[9:0];
                lb_wdata <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_drawer.sv
// tb/tb_sprite_drawer.sv - directed self-checking bench for sprite_drawer
module tb_sprite_drawer;

    logic        clk = 1'b0;
    logic        reset, abort, draw_req, flip;
    logic [9:0]  col_base;
    logic [7:0]  frame_id;
    logic [3:0]  row_off;
    logic        draw_done;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data = 8'd0;
    logic        lb_we;
    logic [9:0]  lb_waddr;
    logic [7:0]  lb_wdata;

    int checks   = 0;
    int failures = 0;
    int rom_mode = 0;

    logic        obs_done [0:31];
    logic        obs_en   [0:31];
    logic        obs_we   [0:31];
    logic [15:0] obs_addr [0:31];
    logic [9:0]  obs_wa   [0:31];
    logic [7:0]  obs_wd   [0:31];

    sprite_drawer dut (
        .clk(clk), .reset(reset), .abort(abort), .draw_req(draw_req),
        .col_base(col_base), .flip(flip), .frame_id(frame_id), .row_off(row_off),
        .draw_done(draw_done), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata)
    );

    always #5 clk = ~clk;

    // Pattern ROM: column c holds c+1; mode 1 makes even columns transparent.
    function automatic logic [7:0] rom_val(input logic [3:0] c);
        if (rom_mode == 1 && c[0] == 1'b0) return 8'd0;
        return {4'd0, c} + 8'd1;
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_val(rom_addr[3:0]);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int k);
        obs_done[k] = draw_done;
        obs_en[k]   = rom_en;
        obs_we[k]   = lb_we;
        obs_addr[k] = rom_addr;
        obs_wa[k]   = lb_waddr;
        obs_wd[k]   = lb_wdata;
    endtask

    // Cycle 0 carries draw_req; cycles 1..ncyc are recorded.
    task automatic run_row(input logic [9:0] base, input logic fl, input logic [7:0] fr,
                           input logic [3:0] rw, input int abort_at, input int busy_at,
                           input int ncyc);
        step;
        col_base = base; flip = fl; frame_id = fr; row_off = rw; draw_req = 1'b1;
        sample(0);
        for (int k = 1; k <= ncyc; k++) begin
            step;
            draw_req = 1'b0;
            abort    = 1'b0;
            sample(k);
            if (k == abort_at) abort = 1'b1;
            if (k == busy_at) begin
                draw_req = 1'b1; col_base = 10'd0; flip = ~fl;
            end
        end
    endtask

    task automatic test_reset;
        checks++; if (draw_done !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", draw_done); end
        checks++; if (lb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", lb_we); end
        checks++; if (lb_waddr !== 10'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", lb_waddr); end
        checks++; if (lb_wdata !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%0d exp=0", lb_wdata); end
        checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
    endtask

    task automatic test_single;
        rom_mode = 0;
        run_row(10'd100, 1'b0, 8'd3, 4'd5, 0, 0, 19);
        checks++; if (obs_done[0] !== 1'b1) begin failures++; $display("FAIL single_done_c0 got=%b exp=1", obs_done[0]); end
        for (int k = 1; k <= 19; k++) begin
            checks++; if (obs_done[k] !== (k == 19)) begin failures++; $display("FAIL single_done c%0d got=%b exp=%b", k, obs_done[k], k == 19); end
            checks++; if (obs_en[k] !== (k <= 16)) begin failures++; $display("FAIL single_rom_en c%0d got=%b exp=%b", k, obs_en[k], k <= 16); end
            if (k <= 16) begin
                checks++; if (obs_addr[k] !== 16'h0350 + 16'(k - 1)) begin failures++; $display("FAIL single_rom_addr c%0d got=%h exp=%h", k, obs_addr[k], 16'h0350 + 16'(k - 1)); end
            end
            checks++; if (obs_we[k] !== (k >= 3 && k <= 18)) begin failures++; $display("FAIL single_we c%0d got=%b", k, obs_we[k]); end
            if (k >= 3 && k <= 18) begin
                checks++; if (obs_wa[k] !== 10'(97 + k) || obs_wd[k] !== 8'(k - 2)) begin failures++; $display("FAIL single_write c%0d got=%0d/%0d exp=%0d/%0d", k, obs_wa[k], obs_wd[k], 97 + k, k - 2); end
            end
        end
    endtask

    task automatic test_flip;
        rom_mode = 0;
        run_row(10'd100, 1'b1, 8'd3, 4'd5, 0, 0, 19);
        for (int k = 1; k <= 19; k++) begin
            if (k <= 16) begin
                checks++; if (obs_addr[k] !== 16'h035F - 16'(k - 1)) begin failures++; $display("FAIL flip_rom_addr c%0d got=%h exp=%h", k, obs_addr[k], 16'h035F - 16'(k - 1)); end
            end
            checks++; if (obs_we[k] !== (k >= 3 && k <= 18)) begin failures++; $display("FAIL flip_we c%0d got=%b", k, obs_we[k]); end
            if (k >= 3 && k <= 18) begin
                checks++; if (obs_wa[k] !== 10'(97 + k) || obs_wd[k] !== 8'(19 - k)) begin failures++; $display("FAIL flip_write c%0d got=%0d/%0d exp=%0d/%0d", k, obs_wa[k], obs_wd[k], 97 + k, 19 - k); end
            end
        end
        checks++; if (obs_done[19] !== 1'b1) begin failures++; $display("FAIL flip_done_c19 got=%b exp=1", obs_done[19]); end
    endtask

    task automatic test_transparency;
        int nw = 0;
        rom_mode = 1;
        run_row(10'd100, 1'b0, 8'd3, 4'd5, 0, 0, 19);
        for (int k = 1; k <= 19; k++) begin
            if (obs_we[k] === 1'b1) nw++;
            if (k >= 3 && k <= 18) begin
                checks++; if (obs_we[k] !== ((k - 3) % 2 == 1)) begin failures++; $display("FAIL transp_we c%0d got=%b exp=%b", k, obs_we[k], (k - 3) % 2 == 1); end
                if ((k - 3) % 2 == 1) begin
                    checks++; if (obs_wa[k] !== 10'(97 + k) || obs_wd[k] !== 8'(k - 2)) begin failures++; $display("FAIL transp_write c%0d got=%0d/%0d exp=%0d/%0d", k, obs_wa[k], obs_wd[k], 97 + k, k - 2); end
                end
            end
        end
        checks++; if (nw != 8) begin failures++; $display("FAIL transp_count got=%0d exp=8", nw); end
        checks++; if (obs_done[18] !== 1'b0 || obs_done[19] !== 1'b1) begin failures++; $display("FAIL transp_done got=%b%b exp=01", obs_done[18], obs_done[19]); end
        rom_mode = 0;
    endtask

    task automatic test_clip;
        int nw = 0;
        rom_mode = 0;
        run_row(10'd630, 1'b0, 8'd3, 4'd5, 0, 0, 19);
        for (int k = 1; k <= 19; k++) begin
            checks++; if (obs_we[k] !== (k >= 3 && k <= 12)) begin failures++; $display("FAIL clip630_we c%0d got=%b exp=%b", k, obs_we[k], k >= 3 && k <= 12); end
            if (k >= 3 && k <= 12) begin
                checks++; if (obs_wa[k] !== 10'(627 + k) || obs_wd[k] !== 8'(k - 2)) begin failures++; $display("FAIL clip630_write c%0d got=%0d/%0d exp=%0d/%0d", k, obs_wa[k], obs_wd[k], 627 + k, k - 2); end
            end
        end
        run_row(10'd700, 1'b0, 8'd3, 4'd5, 0, 0, 19);
        for (int k = 1; k <= 19; k++) if (obs_we[k] === 1'b1) nw++;
        checks++; if (nw != 0) begin failures++; $display("FAIL clip700_count got=%0d exp=0", nw); end
        checks++; if (obs_done[18] !== 1'b0 || obs_done[19] !== 1'b1) begin failures++; $display("FAIL clip700_done got=%b%b exp=01", obs_done[18], obs_done[19]); end
    endtask

    task automatic test_abort;
        rom_mode = 0;
        // Abort during c8, stray request during c5.
        run_row(10'd100, 1'b0, 8'd3, 4'd5, 8, 5, 9);
        for (int k = 1; k <= 9; k++) begin
            checks++; if (obs_we[k] !== (k >= 3 && k <= 8)) begin failures++; $display("FAIL abort_we c%0d got=%b exp=%b", k, obs_we[k], k >= 3 && k <= 8); end
            if (k >= 3 && k <= 8) begin
                checks++; if (obs_wa[k] !== 10'(97 + k) || obs_wd[k] !== 8'(k - 2)) begin failures++; $display("FAIL abort_write c%0d got=%0d/%0d exp=%0d/%0d", k, obs_wa[k], obs_wd[k], 97 + k, k - 2); end
            end
        end
        checks++; if (obs_done[8] !== 1'b0 || obs_done[9] !== 1'b1) begin failures++; $display("FAIL abort_done got=%b%b exp=01", obs_done[8], obs_done[9]); end
        checks++; if (obs_en[9] !== 1'b0) begin failures++; $display("FAIL abort_rom_en got=%b exp=0", obs_en[9]); end
        // New request in c10 renders normally.
        run_row(10'd200, 1'b0, 8'd3, 4'd5, 0, 0, 19);
        for (int k = 3; k <= 18; k++) begin
            checks++; if (obs_we[k] !== 1'b1 || obs_wa[k] !== 10'(197 + k) || obs_wd[k] !== 8'(k - 2)) begin failures++; $display("FAIL abort_rerun c%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, obs_we[k], obs_wa[k], obs_wd[k], 197 + k, k - 2); end
        end
        checks++; if (obs_done[19] !== 1'b1) begin failures++; $display("FAIL abort_rerun_done got=%b exp=1", obs_done[19]); end
        // abort and draw_req together: request dropped.
        step;
        draw_req = 1'b1; abort = 1'b1;
        step;
        draw_req = 1'b0; abort = 1'b0;
        checks++; if (draw_done !== 1'b1 || rom_en !== 1'b0) begin failures++; $display("FAIL abort_vs_req got=%b/%b exp=1/0", draw_done, rom_en); end
        step;
        checks++; if (draw_done !== 1'b1 || rom_en !== 1'b0) begin failures++; $display("FAIL abort_vs_req_next got=%b/%b exp=1/0", draw_done, rom_en); end
    endtask

    task automatic test_back_to_back;
        int pend = 2;
        logic [9:0] wa_q[$];
        logic [7:0] wd_q[$];
        rom_mode = 0;
        for (int c = 0; c < 60; c++) begin
            step;
            if (lb_we === 1'b1) begin wa_q.push_back(lb_waddr); wd_q.push_back(lb_wdata); end
            if (draw_done && !draw_req && pend > 0) begin
                col_base = (pend == 2) ? 10'd200 : 10'd300;
                flip     = (pend == 2) ? 1'b0 : 1'b1;
                frame_id = 8'd1; row_off = 4'd2;
                draw_req = 1'b1;
                pend--;
            end else begin
                draw_req = 1'b0;
            end
        end
        checks++; if (wa_q.size() != 32) begin failures++; $display("FAIL b2b_count got=%0d exp=32", wa_q.size()); end
        for (int p = 0; p < 32 && p < wa_q.size(); p++) begin
            checks++;
            if (p < 16) begin
                if (wa_q[p] !== 10'(200 + p) || wd_q[p] !== 8'(p + 1)) begin failures++; $display("FAIL b2b_a_write %0d got=%0d/%0d exp=%0d/%0d", p, wa_q[p], wd_q[p], 200 + p, p + 1); end
            end else begin
                if (wa_q[p] !== 10'(284 + p) || wd_q[p] !== 8'(32 - p)) begin failures++; $display("FAIL b2b_b_write %0d got=%0d/%0d exp=%0d/%0d", p, wa_q[p], wd_q[p], 284 + p, 32 - p); end
            end
        end
        // Reset mid-row.
        step;
        col_base = 10'd50; flip = 1'b0; draw_req = 1'b1;
        step;
        draw_req = 1'b0;
        repeat (5) step;
        checks++; if (lb_we !== 1'b1) begin failures++; $display("FAIL midrow_we_before_reset got=%b exp=1", lb_we); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++; if (lb_we !== 1'b0 || lb_waddr !== 10'd0 || lb_wdata !== 8'd0) begin failures++; $display("FAIL midrow_reset_lb got=%b/%0d/%0d exp=0/0/0", lb_we, lb_waddr, lb_wdata); end
        checks++; if (rom_en !== 1'b0 || draw_done !== 1'b1) begin failures++; $display("FAIL midrow_reset_ctl got=%b/%b exp=0/1", rom_en, draw_done); end
    endtask

    initial begin
        reset = 1'b1; abort = 1'b0; draw_req = 1'b0; flip = 1'b0;
        col_base = '0; frame_id = '0; row_off = '0;
        repeat (3) step;
        test_reset;
        reset = 1'b0;
        step;
        test_single;
        test_flip;
        test_transparency;
        test_clip;
        test_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_drawer.md
Name: sprite_drawer

Overview:
Consumes one draw request at a time from the sprite frontend and renders one 16-pixel sprite row into the next-line buffer. It fetches palette indices from the synchronous sprite pattern ROM one pixel per cycle. Per pixel it applies horizontal flip, transparency and right-edge clipping, then issues registered line-buffer writes. Line-buffer double buffering and scan-out belong to the line buffer, not this block.

Parameters:
LINE_W, 640, visible pixels per line; columns >= LINE_W are clipped
PIX_W, 8, palette index width (ROM data and line-buffer data)
TRANSP_IDX, 0, palette index treated as transparent (never written)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
abort  in  1  cancel current sprite (driven by start_row); synchronous
draw_req  in  1  one-cycle request pulse from frontend
col_base  in  10  screen column of sprite pixel 0
flip  in  1  horizontal mirror
frame_id  in  8  pattern frame number
row_off  in  4  row within 16-row sprite
draw_done  out  1  1 = idle/ready, 0 = busy
rom_addr  out  16  {frame, row, pixel column} to pattern ROM
rom_en  out  1  ROM read enable
rom_data  in  PIX_W  ROM read data, valid one cycle after rom_en
lb_we  out  1  line-buffer write enable (registered)
lb_waddr  out  10  line-buffer column (registered)
lb_wdata  out  PIX_W  palette index (registered)

Behaviour:
- Reset values: draw_done=1, lb_we=0, lb_waddr=0, lb_wdata=0, rom_en=0, state=IDLE.
- States: IDLE, FETCH, DRAIN.
- IDLE: draw_done=1. On a clk edge with draw_req=1, latch col_base, flip, frame_id and row_off; set i=0; go to FETCH; draw_done=0 from the next cycle. draw_done therefore reads 1 during the draw_req cycle and 0 the cycle after, and the frontend relies on this.
- FETCH: rom_en=1, rom_addr={frame, row, flip ? 4'(15-i) : i}. i increments each cycle. After i=15, go to DRAIN.
- Pipeline: the pixel index (i) is delayed one cycle alongside rom_data.
- Screen column = col_base + i_d, computed as an 11-bit sum (no wrap).
- Register lb_we = valid_d && rom_data != TRANSP_IDX && col < LINE_W. lb_waddr = col[9:0], lb_wdata = rom_data. lb_we stays 0 when not writing.
- DRAIN: rom_en=0. Lasts 2 cycles to flush the data stage and the write-register stage, then returns to IDLE. draw_done=1 from the cycle after the last possible write.
- Latency, counting cycle 1 as the cycle after the draw_req edge:
  - addresses issued c1..c16
  - rom_data valid c2..c17
  - lb writes c3..c18
  - draw_done=0 c1..c18, draw_done=1 at c19 (busy 18 cycles)
- draw_req while busy (state != IDLE) is ignored, with no latch and no queueing.
- abort, any state: next cycle state=IDLE, draw_done=1, lb_we=0, rom_en=0. In-flight pixels are discarded. If abort and draw_req coincide, abort wins and the request is dropped.
- reset overrides abort and draw_req.
- col_base >= LINE_W: the whole row is clipped, but the sprite still takes the full 18-cycle busy time (deterministic timing).

Decomposition:
- Package sprite_pkg holds: SPR_SIZE=16, LINE_W, PIX_W, TRANSP_IDX, the drawer state enum, and a function for the ROM address pack ({frame,row,col}). The frontend's ent_t also moves into this package.
- No sub-module: the datapath is a single two-stage pipeline.

Test Plan:
1. Single sprite: draw_req with col_base=100, flip=0, frame=3, row=5, and ROM row returning i+1 → 16 writes at addr 100..115 with data 1..16 in c3..c18; rom_addr=0x0350+i; draw_done low c1..c18, high c19.
2. Flip: same stimulus with flip=1 → addr 100 gets data 16, addr 115 gets data 1; rom_addr sequence 0x035F down to 0x0350.
3. Transparency: ROM returns 0 for even i → lb_we is asserted only for the 8 odd columns (101,103,...,115); timing unchanged.
4. Clip: col_base=630 → writes only at 630..639 (10 writes), none with addr >= 640 and no wrap to 0..5; col_base=700 → zero writes, draw_done still returns at c19.
5. Abort mid-row: abort at c8 → no lb_we from c9 on, draw_done=1 at c9; a new draw_req at c10 renders normally. A draw_req during busy (c5) produces no extra writes.
6. Back-to-back: model the frontend issuing the next draw_req when draw_done && !draw_req → two sprites fully rendered with no lost or duplicated writes; reset mid-row returns all outputs to reset values the next cycle.
